eth_link_mux: RTL and testbench
===============================

ETH_LINK_MUX -- requirements
Module: eth_link_mux

Interface
REQ-001 Parameter NLP_PERIOD, default 640000, NLP repetition interval in clk cycles (16 ms at 40 MHz).
REQ-002 Parameter NLP_WIDTH, default 4, NLP high time in clk cycles (100 ns).
REQ-003 Parameter TPIDL_LEN, default 12, end-of-frame TP_IDL positive hold in clk cycles (300 ns).
REQ-004 clk  input  1  single system clock, 40 MHz; all logic on posedge clk.
REQ-005 rst  input  1  synchronous, active-high reset, sampled on posedge clk.
REQ-006 clk_eth  input  1  half-bit strobe from the transmitter stage; carried for alignment only.
REQ-007 tx_en  input  1  high while the upstream Manchester encoder is sending a frame.
REQ-008 tx_in  input  1  Manchester line level from the upstream encoder; valid only while tx_en=1.
REQ-009 tx_p  output  1  positive line drive, registered.
REQ-010 tx_n  output  1  negative line drive, registered.
REQ-011 link_pulse  output  1  high during each NLP.
REQ-012 busy  output  1  high in FRAME or TPIDL states.

Function
REQ-013 States: IDLE, NLP, FRAME, TPIDL, held in one registered state variable.
REQ-014 IDLE: tx_p=0, tx_n=0 (differential zero); 20-bit interval timer increments each cycle.
REQ-015 IDLE -> NLP when timer reaches NLP_PERIOD-1; timer then clears to 0.
REQ-016 NLP: tx_p=1, tx_n=0, link_pulse=1 for exactly NLP_WIDTH cycles, then -> IDLE.
REQ-017 Interval timer keeps counting during NLP, so NLP leading edges are exactly NLP_PERIOD cycles apart.
REQ-018 Any state -> FRAME on the cycle tx_en=1 is sampled; timer clears to 0 and is held at 0 while in FRAME.
REQ-019 tx_en in NLP aborts the pulse immediately; link_pulse drops on the same edge the frame data appears.
REQ-020 FRAME: tx_p=tx_in, tx_n=~tx_in, both registered; latency tx_in to tx_p is exactly 1 clk cycle.
REQ-021 FRAME -> TPIDL on first cycle tx_en=0; TPIDL drives tx_p=1, tx_n=0 for TPIDL_LEN cycles, then -> IDLE.
REQ-022 tx_en reasserted during TPIDL -> FRAME immediately; TP_IDL is truncated.
REQ-023 Timer restarts from 0 on TPIDL exit, so first NLP follows NLP_PERIOD cycles after TP_IDL ends.
REQ-024 tx_p and tx_n are never both 1 in any state or cycle.
REQ-025 Pulse and TP_IDL counters are width ceil(log2(max length+1)); no wrap is reachable, and counters saturate rather than wrap.
REQ-026 clk_eth does not gate state transitions; its only use is an optional debug alignment check.

Reset
REQ-027 While rst=1: state=IDLE, all timers=0, tx_p=0, tx_n=0, link_pulse=0, busy=0 on the next edge.
REQ-028 rst mid-NLP, mid-FRAME or mid-TPIDL: outputs go to 0 on the next edge; no TP_IDL is emitted.
REQ-029 After rst release, first NLP leading edge occurs NLP_PERIOD cycles later unless tx_en intervenes.
REQ-030 rst has priority over tx_en.

Structure
REQ-031 Shared include eth_defs.vh holds the state encodings and the default NLP_PERIOD, NLP_WIDTH and TPIDL_LEN at 40 MHz.
REQ-032 One sub-module, eth_nlp_timer, holds the interval counter with clear and hold inputs and a terminal-count output; the FSM and output registers live in eth_link_mux.

Verification (NLP_PERIOD=100, NLP_WIDTH=4, TPIDL_LEN=12)
REQ-033 Idle after reset -> link_pulse high for 4 cycles at cycles 100, 200, 300; tx_n=0 throughout.
REQ-034 tx_en=1 for 64 cycles with alternating tx_in -> tx_p mirrors tx_in 1 cycle late, and tx_n is its complement.
REQ-035 End of that frame -> tx_p=1 for 12 cycles, then 0/0; next NLP 100 cycles after TPIDL exit.
REQ-036 tx_en rises 2 cycles into an NLP -> link_pulse drops and frame data is driven on the next edge.
REQ-037 tx_en reasserted 5 cycles into TPIDL -> FRAME resumes with no IDLE cycle; busy stays 1.
REQ-038 rst pulsed mid-frame -> tx_p=tx_n=0 and busy=0 on the next edge; first NLP at cycle 100 after release.

Source files
------------

// File: rtl/eth_link_mux_pkg.sv
// Shared definitions for the Ethernet link-pulse / frame output mux:
// FSM state encoding and default timing at a 40 MHz system clock.
package eth_link_mux_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_NLP   = 2'd1,
    ST_FRAME = 2'd2,
    ST_TPIDL = 2'd3
  } state_t;

  localparam int unsigned TIMER_W        = 20;
  localparam int unsigned NLP_PERIOD_DEF = 640000;  // 16 ms
  localparam int unsigned NLP_WIDTH_DEF  = 4;       // 100 ns
  localparam int unsigned TPIDL_LEN_DEF  = 12;      // 300 ns

endpackage

// File: rtl/eth_nlp_timer.sv
// Free-running NLP interval counter with clear/hold and a terminal-count flag.
// Clear beats hold; the counter saturates instead of wrapping.
module eth_nlp_timer
  import eth_link_mux_pkg::*;
#(
  parameter int unsigned NLP_PERIOD = NLP_PERIOD_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic hold,
  output logic tc
);

  localparam logic [TIMER_W-1:0] LAST = TIMER_W'(NLP_PERIOD - 1);

  logic [TIMER_W-1:0] count;

  always_ff @(posedge clk) begin
    if (rst || clr)
      count <= '0;
    else if (!hold && count != '1)
      count <= count + 1'b1;
  end

  assign tc = (count == LAST);

endmodule

// File: rtl/eth_link_mux.sv
// 10BASE-T line output mux: normal link pulses while idle, Manchester frame
// data while tx_en is high, and a TP_IDL positive hold after each frame.
module eth_link_mux
  import eth_link_mux_pkg::*;
#(
  parameter int unsigned NLP_PERIOD = NLP_PERIOD_DEF,
  parameter int unsigned NLP_WIDTH  = NLP_WIDTH_DEF,
  parameter int unsigned TPIDL_LEN  = TPIDL_LEN_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic clk_eth,
  input  logic tx_en,
  input  logic tx_in,
  output logic tx_p,
  output logic tx_n,
  output logic link_pulse,
  output logic busy
);

  localparam int unsigned PW = $clog2(NLP_WIDTH + 1);
  localparam int unsigned TW = $clog2(TPIDL_LEN + 1);
  localparam logic [PW-1:0] PULSE_LAST = PW'(NLP_WIDTH);
  localparam logic [TW-1:0] TPIDL_LAST = TW'(TPIDL_LEN);

  state_t        state;
  logic [PW-1:0] pulse_cnt;
  logic [TW-1:0] tpidl_cnt;
  logic          tc;
  logic          timer_clr;
  logic          timer_hold;

  // clk_eth is only a debug alignment reference and never steers the FSM.
  logic unused_clk_eth;
  assign unused_clk_eth = clk_eth;

  // Timer restarts at each NLP launch, at frame start and throughout TP_IDL,
  // so the post-frame interval is measured from the TP_IDL exit edge.
  assign timer_clr  = tx_en || (state == ST_TPIDL) || (state == ST_IDLE && tc);
  assign timer_hold = (state == ST_FRAME);

  eth_nlp_timer #(
    .NLP_PERIOD (NLP_PERIOD)
  ) u_timer (
    .clk  (clk),
    .rst  (rst),
    .clr  (timer_clr),
    .hold (timer_hold),
    .tc   (tc)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      pulse_cnt  <= '0;
      tpidl_cnt  <= '0;
      tx_p       <= 1'b0;
      tx_n       <= 1'b0;
      link_pulse <= 1'b0;
      busy       <= 1'b0;
    end else if (tx_en) begin
      state      <= ST_FRAME;
      pulse_cnt  <= '0;
      tpidl_cnt  <= '0;
      tx_p       <= tx_in;
      tx_n       <= ~tx_in;
      link_pulse <= 1'b0;
      busy       <= 1'b1;
    end else begin
      case (state)
        ST_IDLE: begin
          if (tc) begin
            state      <= ST_NLP;
            pulse_cnt  <= PW'(1);
            tx_p       <= 1'b1;
            tx_n       <= 1'b0;
            link_pulse <= 1'b1;
          end else begin
            tx_p       <= 1'b0;
            tx_n       <= 1'b0;
            link_pulse <= 1'b0;
          end
          busy <= 1'b0;
        end
        ST_NLP: begin
          if (pulse_cnt == PULSE_LAST) begin
            state      <= ST_IDLE;
            pulse_cnt  <= '0;
            tx_p       <= 1'b0;
            link_pulse <= 1'b0;
          end else begin
            pulse_cnt <= pulse_cnt + 1'b1;
          end
        end
        ST_FRAME: begin
          state     <= ST_TPIDL;
          tpidl_cnt <= TW'(1);
          tx_p      <= 1'b1;
          tx_n      <= 1'b0;
          busy      <= 1'b1;
        end
        ST_TPIDL: begin
          if (tpidl_cnt == TPIDL_LAST) begin
            state     <= ST_IDLE;
            tpidl_cnt <= '0;
            tx_p      <= 1'b0;
            tx_n      <= 1'b0;
            busy      <= 1'b0;
          end else begin
            tpidl_cnt <= tpidl_cnt + 1'b1;
          end
        end
        default: begin
          state      <= ST_IDLE;
          tx_p       <= 1'b0;
          tx_n       <= 1'b0;
          link_pulse <= 1'b0;
          busy       <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_eth_link_mux.sv
// Directed bench for eth_link_mux with short timing parameters; expected line
// states are queued as each cycle is driven and compared after the edge.
module tb_eth_link_mux;

  localparam int unsigned P = 100;
  localparam int unsigned W = 4;
  localparam int unsigned T = 12;

  localparam logic [3:0] E_ZERO  = 4'b0000;  // {tx_p, tx_n, link_pulse, busy}
  localparam logic [3:0] E_NLP   = 4'b1010;
  localparam logic [3:0] E_TPIDL = 4'b1001;

  logic clk = 1'b0;
  logic clk_eth = 1'b0;
  logic rst, tx_en, tx_in;
  logic tx_p, tx_n, link_pulse, busy;

  int checks = 0;
  int failures = 0;
  logic [3:0] sb_q[$];

  always #5 clk = ~clk;
  always #10 clk_eth = ~clk_eth;

  eth_link_mux #(
    .NLP_PERIOD (P),
    .NLP_WIDTH  (W),
    .TPIDL_LEN  (T)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .clk_eth    (clk_eth),
    .tx_en      (tx_en),
    .tx_in      (tx_in),
    .tx_p       (tx_p),
    .tx_n       (tx_n),
    .link_pulse (link_pulse),
    .busy       (busy)
  );

  task automatic cyc(input logic r, input logic en, input logic din,
                     input logic [3:0] exp, input string tag);
    logic [3:0] got;
    logic [3:0] want;
    rst   = r;
    tx_en = en;
    tx_in = din;
    sb_q.push_back(exp);
    @(posedge clk);
    #1;
    got = {tx_p, tx_n, link_pulse, busy};
    checks++;
    if (sb_q.size() == 0) begin
      failures++;
      $error("FAIL %s: scoreboard empty observed=%b", tag, got);
    end else begin
      want = sb_q.pop_front();
      assert (got === want) else begin
        failures++;
        $error("FAIL %s: {tx_p,tx_n,link_pulse,busy} observed=%b expected=%b", tag, got, want);
      end
    end
    checks++;
    assert (!(tx_p === 1'b1 && tx_n === 1'b1)) else begin
      failures++;
      $error("FAIL %s_excl: tx_p/tx_n observed=%b%b expected not 11", tag, tx_p, tx_n);
    end
  endtask

  // Idle edges counted from the last reset/TP_IDL-exit edge: pulses at k*P .. k*P+W-1.
  task automatic idle_run(input int unsigned k0, input int unsigned k1, input string tag);
    for (int unsigned k = k0; k <= k1; k++)
      cyc(1'b0, 1'b0, 1'b0, (k >= P && (k % P) < W) ? E_NLP : E_ZERO, tag);
  endtask

  initial begin
    rst = 1'b1; tx_en = 1'b0; tx_in = 1'b0;

    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 1'b0, E_ZERO, "reset");

    idle_run(1, 310, "idle_nlp");

    // Frame starts 2 cycles into the NLP at edge 400.
    idle_run(311, 401, "pre_abort");
    for (int i = 0; i < 64; i++)
      cyc(1'b0, 1'b1, i[0], {i[0], ~i[0], 1'b0, 1'b1}, (i == 0) ? "nlp_abort" : "frame");

    for (int unsigned i = 0; i < T; i++) cyc(1'b0, 1'b0, 1'b0, E_TPIDL, "tpidl");
    cyc(1'b0, 1'b0, 1'b0, E_ZERO, "tpidl_exit");
    idle_run(1, 104, "post_frame_nlp");

    // TP_IDL truncated after 5 cycles; frame resumes without an idle gap.
    for (int i = 0; i < 8; i++)
      cyc(1'b0, 1'b1, ~i[0], {~i[0], i[0], 1'b0, 1'b1}, "frame2");
    for (int i = 0; i < 5; i++) cyc(1'b0, 1'b0, 1'b0, E_TPIDL, "tpidl_short");
    cyc(1'b0, 1'b1, 1'b0, 4'b0101, "tpidl_trunc");
    for (int i = 0; i < 6; i++)
      cyc(1'b0, 1'b1, i[0], {i[0], ~i[0], 1'b0, 1'b1}, "frame3");

    // Reset with tx_en still high: reset wins, no TP_IDL follows.
    cyc(1'b1, 1'b1, 1'b1, E_ZERO, "rst_mid_frame");
    idle_run(1, 101, "post_rst_nlp");

    cyc(1'b1, 1'b0, 1'b0, E_ZERO, "rst_mid_nlp");
    idle_run(1, 5, "post_rst_idle");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
